spi_req_arbiter: RTL
====================

Name: spi_req_arbiter

Overview:
- Shares one spi_master instance among NUM_REQ requesters using round-robin arbitration.
- Each transaction is one DATA_WIDTH-bit word: the block launches it on the master, waits for `finish`, and returns the received word to the requester that owns it.
- Sits between client logic and spi_master, and drives the master's `start` and `data_in`.
- A watchdog recovers from a master that never signals `finish`.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 8, word width; must equal the spi_master DATA_WIDTH.
- TIMEOUT_CYCLES, 1024, maximum clk cycles spent in WAIT before abort (at least 2).
- SEL_W, $clog2(NUM_REQ), width of grant_id.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  reset: synchronous, active-low.
- req_valid  in  NUM_REQ  request pending, one bit per requester.
- req_data  in  NUM_REQ*DATA_WIDTH  MOSI word; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  one-hot, single-cycle accept pulse.
- rsp_valid  out  NUM_REQ  one-hot, single-cycle response pulse.
- rsp_data  out  DATA_WIDTH  received MISO word; valid while any rsp_valid bit is high.
- timeout_err  out  1  single-cycle pulse, concurrent with rsp_valid on abort.
- grant_id  out  SEL_W  index of the current or last granted requester.
- busy  out  1  high whenever the state is not IDLE.
- m_start  out  1  start pulse to spi_master.
- m_data_in  out  DATA_WIDTH  data_in to spi_master.
- m_finish  in  1  finish from spi_master.
- m_data_out  in  DATA_WIDTH  data_out from spi_master.

Behaviour:

*Reset*
- rst_n is sampled on the clk rising edge only.
- On reset, all outputs go to 0, state goes to IDLE and last_grant goes to NUM_REQ-1, so requester 0 has top priority first.
- Reset mid-transaction aborts it with no rsp_valid and no timeout_err. rst_n also resets spi_master.

*Registers and handshake*
- All outputs are registered.
- A requester holds req_valid and req_data stable until it sees its req_ready bit. Dropping req_valid before then is illegal.
- Each accepted request produces exactly one rsp_valid pulse on the same bit index.

*State machine: IDLE -> LAUNCH -> WAIT -> GAP -> IDLE*
- **IDLE.** If req_valid is nonzero at edge T:
  - g = first set bit scanning from (last_grant+1) mod NUM_REQ upward, with wrap-around.
  - At T+1: state = LAUNCH, req_ready[g] = 1, m_start = 1, m_data_in = req_data[g], grant_id = g.
  - If req_valid is zero, stay in IDLE.
- **LAUNCH** (one cycle):
  - Clear req_ready and m_start.
  - Clear wait_cnt.
  - Go to WAIT.
  - m_data_in is held until the next launch.
- **WAIT.** wait_cnt increments every cycle.
  - If m_finish = 1: rsp_data = m_data_out, rsp_valid[grant_id] = 1, last_grant = grant_id, go to GAP.
  - Else if wait_cnt == TIMEOUT_CYCLES-1: rsp_data = 0, rsp_valid[grant_id] = 1, timeout_err = 1, last_grant = grant_id, go to GAP.
  - If both conditions occur in the same cycle, m_finish wins and no error is flagged.
- **GAP** (one cycle):
  - Clear rsp_valid and timeout_err.
  - Go to IDLE.
  - The gap guarantees spi_master has returned to its IDLE before the next start.

*Arbitration rules*
- m_finish is ignored in every state except WAIT.
- Requests arriving during LAUNCH, WAIT or GAP wait for IDLE. No request is lost.
- New arrivals do not change an arbitration decision already registered.
- Minimum launch-to-launch spacing is the master transfer time plus 3 cycles.
- Fairness: a continuously asserting requester can be granted at most once between two grants of any other continuously asserting requester.

Test Plan:
- **Single request.** NUM_REQ=4, req_valid=0010, req_data[1]=0xA5, master loopback returns 0x3C.
  - Expect req_ready=0010 and m_start=1 with m_data_in=0xA5 one cycle after valid is seen.
  - Expect rsp_valid=0010 and rsp_data=0x3C one cycle after m_finish.
  - Expect busy low after GAP.
- **Round-robin.** All four req_valid held high continuously.
  - Expect grant order 0,1,2,3,0,1 after reset.
  - Expect exactly one rsp_valid per grant, on the matching index.
- **Wrap and skip.** last_grant=2 and req_valid=0011 → grant 0, then grant 1. Then req_valid=0001 alone → grant 0 again.
- **Timeout.** TIMEOUT_CYCLES=16, m_finish tied low.
  - Expect rsp_valid[g] and timeout_err high 16 cycles after LAUNCH, with rsp_data=0.
  - Expect the next request to proceed normally.
- **Finish coinciding with timeout.** m_finish asserted on the terminal WAIT cycle → rsp_data = m_data_out, timeout_err=0.
- **Stray finish and mid-transaction reset.**
  - m_finish pulsed in IDLE → no rsp_valid.
  - rst_n low for 1 cycle during WAIT → all outputs 0 at the next cycle, no rsp_valid, and grant 0 has priority afterwards.

Source files
------------

// File: rtl/spi_req_arbiter.sv
// spi_req_arbiter: round-robin sharing of one spi_master among NUM_REQ single-word requesters
module spi_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int SEL_W          = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          timeout_err,
  output logic [SEL_W-1:0]              grant_id,
  output logic                          busy,
  output logic                          m_start,
  output logic [DATA_WIDTH-1:0]         m_data_in,
  input  logic                          m_finish,
  input  logic [DATA_WIDTH-1:0]         m_data_out
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, GAP} state_t;
  state_t                state, state_n;
  logic [SEL_W-1:0]      last_grant, last_n, grant_n, pick;
  logic [NUM_REQ-1:0]    ready_n, rsp_valid_n;
  logic [DATA_WIDTH-1:0] rsp_data_n, m_data_n;
  logic                  terr_n, start_n;
  logic [CNT_W-1:0]      wait_cnt, cnt_n;
  assign busy = state != IDLE;
  // round-robin pick: lowest requester above last_grant, otherwise lowest overall (wrap)
  always_comb begin
    pick = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) if (req_valid[i]) pick = SEL_W'(i);
    for (int i = NUM_REQ - 1; i >= 0; i--) if (req_valid[i] && i > int'(last_grant)) pick = SEL_W'(i);
  end
  // next state and next registered outputs; pulses default low so LAUNCH and GAP clear them
  always_comb begin
    state_n     = state;
    last_n      = last_grant;
    grant_n     = grant_id;
    ready_n     = '0;
    start_n     = 1'b0;
    rsp_valid_n = '0;
    terr_n      = 1'b0;
    rsp_data_n  = rsp_data;
    m_data_n    = m_data_in;
    cnt_n       = wait_cnt + 1'b1;
    unique case (state)
      IDLE: if (|req_valid) begin
        state_n  = LAUNCH;
        grant_n  = pick;
        ready_n  = NUM_REQ'(1) << pick;
        start_n  = 1'b1;
        m_data_n = req_data[pick*DATA_WIDTH +: DATA_WIDTH];
      end
      LAUNCH: begin
        state_n = WAIT;
        cnt_n   = '0;
      end
      WAIT: if (m_finish || wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        state_n     = GAP;
        rsp_valid_n = NUM_REQ'(1) << grant_id;
        last_n      = grant_id;
        terr_n      = !m_finish;
        rsp_data_n  = m_finish ? m_data_out : '0;
      end
      GAP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // state and output registers; reset aborts any transaction silently and favours requester 0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= SEL_W'(NUM_REQ - 1);
      grant_id    <= '0;
      req_ready   <= '0;
      m_start     <= 1'b0;
      rsp_valid   <= '0;
      timeout_err <= 1'b0;
      rsp_data    <= '0;
      m_data_in   <= '0;
      wait_cnt    <= '0;
    end else begin
      state       <= state_n;
      last_grant  <= last_n;
      grant_id    <= grant_n;
      req_ready   <= ready_n;
      m_start     <= start_n;
      rsp_valid   <= rsp_valid_n;
      timeout_err <= terr_n;
      rsp_data    <= rsp_data_n;
      m_data_in   <= m_data_n;
      wait_cnt    <= cnt_n;
    end
  end
endmodule
